// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: scaled, colour-keyed sprite layers over a background,
// with timing flags re-aligned to the sprite memory read latency.
module sprite_compositor #(
    parameter int NUM_SPRITES = 2,
    parameter int WIDTH       = 128,
    parameter int HEIGHT      = 128,
    parameter int HCOUNT_W    = 11,
    parameter int VCOUNT_W    = 10,
    parameter int COLOR_W     = 12,
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = $clog2(WIDTH * HEIGHT)
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [HCOUNT_W-1:0]               hcount_in,
    input  logic [VCOUNT_W-1:0]               vcount_in,
    input  logic                              hsync_in,
    input  logic                              vsync_in,
    input  logic                              blank_in,
    input  logic [NUM_SPRITES*HCOUNT_W-1:0]   sprite_x_in,
    input  logic [NUM_SPRITES*VCOUNT_W-1:0]   sprite_y_in,
    input  logic [NUM_SPRITES-1:0]            sprite_en_in,
    input  logic [2*NUM_SPRITES-1:0]          sprite_scale_in,
    input  logic [COLOR_W-1:0]                key_color_in,
    input  logic [COLOR_W-1:0]                bg_color_in,
    output logic [NUM_SPRITES*ADDR_W-1:0]     mem_addr_out,
    input  logic [NUM_SPRITES*COLOR_W-1:0]    mem_data_in,
    output logic [COLOR_W-1:0]                color_out,
    output logic                              hsync_out,
    output logic                              vsync_out,
    output logic                              blank_out
);

    // Flag pipe bit order: {valid, hsync, vsync, blank}
    localparam int F_VALID = 3;
    localparam int F_HSYNC = 2;
    localparam int F_VSYNC = 1;
    localparam int F_BLANK = 0;

    logic                            vs_prev_q;
    logic [NUM_SPRITES*HCOUNT_W-1:0] x_q;
    logic [NUM_SPRITES*VCOUNT_W-1:0] y_q;
    logic [NUM_SPRITES-1:0]          en_q;
    logic [2*NUM_SPRITES-1:0]        scale_q;

    logic [NUM_SPRITES-1:0]          hit_d;
    logic [NUM_SPRITES*ADDR_W-1:0]   addr_d;
    logic [NUM_SPRITES*ADDR_W-1:0]   addr_q;
    logic [NUM_SPRITES-1:0]          hit_pipe_q  [MEM_LATENCY+1];
    logic [3:0]                      flag_pipe_q [MEM_LATENCY+1];

    logic [COLOR_W-1:0]              color_d;
    logic [COLOR_W-1:0]              color_q;
    logic                            hsync_q;
    logic                            vsync_q;
    logic                            blank_q;

    // Sprite position/enable/scale only change on a vsync rising edge, so a frame never tears.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vs_prev_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            en_q      <= '0;
            scale_q   <= '0;
        end else begin
            vs_prev_q <= vsync_in;
            if (vsync_in && !vs_prev_q) begin
                x_q     <= sprite_x_in;
                y_q     <= sprite_y_in;
                en_q    <= sprite_en_in;
                scale_q <= sprite_scale_in;
            end
        end
    end

    // Stage A: hit test and source address per sprite.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        logic [HCOUNT_W:0] dx;
        logic [VCOUNT_W:0] dy;
        logic [1:0]        s;
        logic              in_x;
        logic              in_y;
        hit_d  = '0;
        addr_d = '0;
        dx     = '0;
        dy     = '0;
        s      = '0;
        in_x   = 1'b0;
        in_y   = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            s    = scale_q[2*i +: 2];
            dx   = {1'b0, hcount_in} - {1'b0, x_q[i*HCOUNT_W +: HCOUNT_W]};
            dy   = {1'b0, vcount_in} - {1'b0, y_q[i*VCOUNT_W +: VCOUNT_W]};
            in_x = (hcount_in >= x_q[i*HCOUNT_W +: HCOUNT_W]) && (32'(dx) < (32'(WIDTH) << s));
            in_y = (vcount_in >= y_q[i*VCOUNT_W +: VCOUNT_W]) && (32'(dy) < (32'(HEIGHT) << s));
            hit_d[i] = en_q[i] && in_x && in_y;
            if (hit_d[i]) begin
                addr_d[i*ADDR_W +: ADDR_W] = ADDR_W'(dx >> s) + ADDR_W'(dy >> s) * ADDR_W'(WIDTH);
            end
        end
    end

    // Stage C: lowest-index opaque sprite wins; blank or an unfilled pipeline forces black.
    always_comb begin
        color_d = bg_color_in;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_pipe_q[MEM_LATENCY][i] &&
                (mem_data_in[i*COLOR_W +: COLOR_W] != key_color_in)) begin
                color_d = mem_data_in[i*COLOR_W +: COLOR_W];
            end
        end
        if (flag_pipe_q[MEM_LATENCY][F_BLANK] || !flag_pipe_q[MEM_LATENCY][F_VALID]) begin
            color_d = '0;
        end
    end

    // NOTE: the pipeline arrays are reset too; the valid bit they carry is what keeps output black while refilling.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_q  <= '0;
            color_q <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            blank_q <= 1'b0;
            for (int k = 0; k <= MEM_LATENCY; k++) begin
                hit_pipe_q[k]  <= '0;
                flag_pipe_q[k] <= '0;
            end
        end else begin
            addr_q         <= addr_d;
            hit_pipe_q[0]  <= hit_d;
            flag_pipe_q[0] <= {1'b1, hsync_in, vsync_in, blank_in};
            for (int k = 1; k <= MEM_LATENCY; k++) begin
                hit_pipe_q[k]  <= hit_pipe_q[k-1];
                flag_pipe_q[k] <= flag_pipe_q[k-1];
            end
            color_q <= color_d;
            hsync_q <= flag_pipe_q[MEM_LATENCY][F_HSYNC];
            vsync_q <= flag_pipe_q[MEM_LATENCY][F_VSYNC];
            blank_q <= flag_pipe_q[MEM_LATENCY][F_BLANK];
        end
    end

    assign mem_addr_out = addr_q;
    assign color_out    = color_q;
    assign hsync_out    = hsync_q;
    assign vsync_out    = vsync_q;
    assign blank_out    = blank_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: two instances (memory latency 2 and 1)
// share stimulus, each fed by a small behavioural sprite memory.
module tb_sprite_compositor;

    localparam int NS = 2;
    localparam int HW = 11;
    localparam int VW = 10;
    localparam int CW = 12;
    localparam int AW = 14;

    logic            clk = 1'b0;
    logic            rst;
    logic [HW-1:0]   hcount;
    logic [VW-1:0]   vcount;
    logic            hsync, vsync, blank;
    logic [NS*HW-1:0] sx;
    logic [NS*VW-1:0] sy;
    logic [NS-1:0]   en;
    logic [2*NS-1:0] scale;
    logic [CW-1:0]   key, bg;

    logic [NS*AW-1:0] addr_a, addr_b;
    logic [NS*CW-1:0] data_a, data_b;
    logic [NS*CW-1:0] ma1, ma2, mb1;
    logic [CW-1:0]   color_a, color_b;
    logic            hs_a, vs_a, bl_a, hs_b, vs_b, bl_b;

    int mode;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sprite_compositor #(.MEM_LATENCY(2)) dut_a (
        .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
        .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank),
        .sprite_x_in(sx), .sprite_y_in(sy), .sprite_en_in(en), .sprite_scale_in(scale),
        .key_color_in(key), .bg_color_in(bg), .mem_addr_out(addr_a), .mem_data_in(data_a),
        .color_out(color_a), .hsync_out(hs_a), .vsync_out(vs_a), .blank_out(bl_a)
    );

    sprite_compositor #(.MEM_LATENCY(1)) dut_b (
        .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
        .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank),
        .sprite_x_in(sx), .sprite_y_in(sy), .sprite_en_in(en), .sprite_scale_in(scale),
        .key_color_in(key), .bg_color_in(bg), .mem_addr_out(addr_b), .mem_data_in(data_b),
        .color_out(color_b), .hsync_out(hs_b), .vsync_out(vs_b), .blank_out(bl_b)
    );

    // Mode 0: data is the low 12 address bits; mode 1: constant colour per sprite.
    function automatic logic [CW-1:0] mem_f(input int idx, input logic [AW-1:0] a);
        if (mode == 0) return a[CW-1:0];
        return (idx == 0) ? 12'hF00 : 12'h0F0;
    endfunction

    always @(posedge clk) begin
        ma1 <= {mem_f(1, addr_a[2*AW-1:AW]), mem_f(0, addr_a[AW-1:0])};
        ma2 <= ma1;
        mb1 <= {mem_f(1, addr_b[2*AW-1:AW]), mem_f(0, addr_b[AW-1:0])};
    end
    assign data_a = ma2;
    assign data_b = mb1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pix(input int h, input int v);
        hcount = HW'(h);
        vcount = VW'(v);
    endtask

    task automatic place(input int i, input int x, input int y, input int s);
        sx[i*HW +: HW]  = HW'(x);
        sy[i*VW +: VW]  = VW'(y);
        scale[2*i +: 2] = 2'(s);
    endtask

    task automatic latch();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    logic [11:0] hs_pat, vs_pat, bl_pat;
    logic [2:0]  hist [16];

    initial begin
        rst = 1'b1; hsync = 1'b1; vsync = 1'b0; blank = 1'b1;
        sx = '0; sy = '0; en = '1; scale = '0;
        key = 12'hABC; bg = 12'h00F; mode = 0;
        pix(5, 3);
        tick(2);
        check("rst_color", color_a, 0);
        check("rst_hsync", hs_a, 0);
        check("rst_blank", bl_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_color_b", color_b, 0);
        rst = 1'b0; hsync = 1'b0; blank = 1'b0; en = '0;

        // Single sprite, 1x
        place(0, 0, 0, 0); place(1, 600, 600, 0); en = 2'b01;
        latch();
        pix(4, 3); tick(4);
        pix(5, 3); tick();
        check("t1_addr_5_3", addr_a[AW-1:0], 389);
        pix(200, 3); tick(2);
        check("t1_before_latency", color_a, 12'h184);
        tick();
        check("t1_pix_5_3", color_a, 12'h185);
        tick();
        check("t1_next_bg", color_a, 12'h00F);
        pix(127, 0); tick(4);
        check("t1_pix_127_0", color_a, 12'h07F);
        pix(128, 0); tick(4);
        check("t1_pix_128_0", color_a, 12'h00F);

        // Scale 2x at (100,50)
        place(0, 100, 50, 1);
        latch();
        pix(101, 50); tick();
        check("t2_addr_101", addr_a[AW-1:0], 0);
        pix(102, 50); tick();
        check("t2_addr_102", addr_a[AW-1:0], 1);
        pix(355, 50); tick();
        check("t2_addr_355", addr_a[AW-1:0], 127);
        tick(3);
        check("t2_color_355", color_a, 12'h07F);
        pix(356, 50); tick();
        check("t2_addr_356", addr_a[AW-1:0], 0);
        tick(3);
        check("t2_color_356", color_a, 12'h00F);
        pix(100, 305); tick();
        check("t2_addr_row127", addr_a[AW-1:0], 16256);
        pix(100, 306); tick(4);
        check("t2_color_row128", color_a, 12'h00F);
        pix(99, 50); tick(4);
        check("t2_color_x99", color_a, 12'h00F);

        // Priority and colour key
        mode = 1;
        place(0, 0, 0, 0); place(1, 0, 0, 0); en = 2'b11;
        latch();
        pix(10, 10); tick(4);
        check("t3_prio", color_a, 12'hF00);
        key = 12'hF00; tick();
        check("t3_key_exposes_1", color_a, 12'h0F0);
        en = 2'b01;
        latch(); tick(4);
        check("t3_key_bg", color_a, 12'h00F);

        // Shadow latch
        mode = 0; key = 12'hABC;
        place(0, 0, 0, 0);
        latch();
        place(0, 200, 0, 0);
        pix(10, 0); tick(4);
        check("t4_old_x_hit", color_a, 12'h00A);
        pix(210, 0); tick(4);
        check("t4_old_x_miss", color_a, 12'h00F);
        latch(); tick(4);
        check("t4_new_x_hit", color_a, 12'h00A);
        pix(10, 0); tick(4);
        check("t4_new_x_miss", color_a, 12'h00F);

        // Blank and sync alignment, latency 4 (dut_a) and 3 (dut_b)
        place(0, 0, 0, 0);
        latch();
        pix(10, 0); tick(4);
        hs_pat = 12'b000111000110;
        vs_pat = 12'b001100000000;
        bl_pat = 12'b110000111010;
        for (int n = 0; n < 16; n++) begin
            if (n < 12) begin
                hsync = hs_pat[n]; vsync = vs_pat[n]; blank = bl_pat[n];
            end else begin
                hsync = 1'b0; vsync = 1'b0; blank = 1'b0;
            end
            hist[n] = {hsync, vsync, blank};
            tick();
            if (n + 1 >= 4) begin
                check("t5_hsync_a", hs_a, hist[n-3][2]);
                check("t5_vsync_a", vs_a, hist[n-3][1]);
                check("t5_blank_a", bl_a, hist[n-3][0]);
                check("t5_color_a", color_a, hist[n-3][0] ? 12'h000 : 12'h00A);
            end
            if (n + 1 >= 3) begin
                check("t5_hsync_b", hs_b, hist[n-2][2]);
                check("t5_vsync_b", vs_b, hist[n-2][1]);
                check("t5_blank_b", bl_b, hist[n-2][0]);
                check("t5_color_b", color_b, hist[n-2][0] ? 12'h000 : 12'h00A);
            end
        end

        // Reset mid-frame
        place(0, 450, 380, 0); en = 2'b01;
        latch();
        pix(500, 400); hsync = 1'b1; tick(4);
        check("t6_pre_color", color_a, 12'hA32);
        check("t6_pre_hsync", hs_a, 1);
        rst = 1'b1; tick();
        check("t6_rst_color", color_a, 0);
        check("t6_rst_hsync", hs_a, 0);
        check("t6_rst_vsync", vs_a, 0);
        check("t6_rst_blank", bl_a, 0);
        check("t6_rst_addr", addr_a, 0);
        check("t6_rst_color_b", color_b, 0);
        rst = 1'b0; tick();
        check("t6_refill_black", color_a, 0);
        check("t6_refill_hsync", hs_a, 0);
        tick(3);
        check("t6_after_refill_bg", color_a, 12'h00F);
        check("t6_after_refill_hsync", hs_a, 1);
        latch(); tick(4);
        check("t6_relatched", color_a, 12'hA32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
